serial_tx_sequencer: RTL and testbench

- Upstream control stage for the 8:1 serial output priority mux.
- Accepts a byte over a valid/ready handshake and holds it stable on the mux data inputs.
- Steps the mux select through bits 0..7, LSB first, at a fixed bit period.
- Drives the mux inactive input during idle and stop bits, and flags the start bit so top level forces the line low.

---
 rtl/serial_tx_sequencer.sv | 114 +++++++++++
 tb/tb_serial_tx_sequencer.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx_sequencer.sv
// Control stage for the 8:1 serial output mux: takes a byte over valid/ready and
// steps the mux select through start, eight LSB-first data bits and the stop bits.
module serial_tx_sequencer #(
    parameter int CLKS_PER_BIT = 434,
    parameter int STOP_BITS    = 1
) (
    input  logic       Clk,
    input  logic       Reset_n,
    input  logic [7:0] tx_byte,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] bit_data,
    output logic [2:0] bit_sel,
    output logic       line_inactive,
    output logic       start_phase,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] NEAR_CNT = CNT_W'(CLKS_PER_BIT - 2);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] baud_cnt;
    logic             stop_cnt;
    logic             last_stop;

    assign last_stop = (STOP_BITS == 1) || stop_cnt;

    // bit_sel doubles as the data bit index; tx_done is raised one cycle early
    // so the registered pulse lands on the final stop-bit cycle.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state         <= IDLE;
            baud_cnt      <= '0;
            stop_cnt      <= 1'b0;
            tx_ready      <= 1'b1;
            bit_data      <= 8'h00;
            bit_sel       <= 3'd0;
            line_inactive <= 1'b1;
            start_phase   <= 1'b0;
            tx_busy       <= 1'b0;
            tx_done       <= 1'b0;
        end else begin
            tx_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tx_valid) begin
                        bit_data      <= tx_byte;
                        baud_cnt      <= '0;
                        bit_sel       <= 3'd0;
                        state         <= START;
                        tx_ready      <= 1'b0;
                        tx_busy       <= 1'b1;
                        line_inactive <= 1'b0;
                        start_phase   <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == LAST_CNT) begin
                        baud_cnt    <= '0;
                        state       <= DATA;
                        start_phase <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                DATA: begin
                    if (baud_cnt == LAST_CNT) begin
                        baud_cnt <= '0;
                        if (bit_sel == 3'd7) begin
                            state         <= STOP;
                            line_inactive <= 1'b1;
                            stop_cnt      <= 1'b0;
                        end else begin
                            bit_sel <= bit_sel + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                STOP: begin
                    if (baud_cnt == NEAR_CNT && last_stop) begin
                        tx_done <= 1'b1;
                    end
                    if (baud_cnt == LAST_CNT) begin
                        baud_cnt <= '0;
                        if (last_stop) begin
                            state    <= IDLE;
                            stop_cnt <= 1'b0;
                            bit_sel  <= 3'd0;
                            tx_ready <= 1'b1;
                            tx_busy  <= 1'b0;
                        end else begin
                            stop_cnt <= 1'b1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_sequencer.sv
// Bench for serial_tx_sequencer: two instances (one and two stop bits) checked every
// cycle against a frame-position model of the reconstructed serial line.
module tb_serial_tx_sequencer;

    localparam int C = 4;

    logic       clk = 1'b0;
    logic       rst_n0 = 1'b0;
    logic       rst_n1 = 1'b0;
    logic [7:0] tx_byte [2] = '{8'h00, 8'h00};
    logic       tx_valid [2] = '{1'b0, 1'b0};

    logic       tx_ready_a, tx_ready_b, line_inactive_a, line_inactive_b;
    logic       start_phase_a, start_phase_b, tx_busy_a, tx_busy_b, tx_done_a, tx_done_b;
    logic [7:0] bit_data_a, bit_data_b;
    logic [2:0] bit_sel_a, bit_sel_b;

    logic       o_ready [2], o_li [2], o_sp [2], o_busy [2], o_done [2];
    logic [7:0] o_data [2];
    logic [2:0] o_sel [2];

    int  check_count = 0;
    int  error_count = 0;
    int  dut_done [2] = '{0, 0};

    bit         m_active [2] = '{1'b0, 1'b0};
    int         m_k [2] = '{0, 0};
    logic [7:0] m_byte [2] = '{8'h00, 8'h00};
    int         m_frames [2] = '{0, 0};
    int         m_starts [2] = '{0, 0};
    time        m_last_start [2] = '{0, 0};
    time        m_prev_start [2] = '{0, 0};

    always #5 clk = ~clk;

    serial_tx_sequencer #(.CLKS_PER_BIT(C), .STOP_BITS(1)) dut_a (
        .Clk(clk), .Reset_n(rst_n0), .tx_byte(tx_byte[0]), .tx_valid(tx_valid[0]),
        .tx_ready(tx_ready_a), .bit_data(bit_data_a), .bit_sel(bit_sel_a),
        .line_inactive(line_inactive_a), .start_phase(start_phase_a),
        .tx_busy(tx_busy_a), .tx_done(tx_done_a)
    );

    serial_tx_sequencer #(.CLKS_PER_BIT(C), .STOP_BITS(2)) dut_b (
        .Clk(clk), .Reset_n(rst_n1), .tx_byte(tx_byte[1]), .tx_valid(tx_valid[1]),
        .tx_ready(tx_ready_b), .bit_data(bit_data_b), .bit_sel(bit_sel_b),
        .line_inactive(line_inactive_b), .start_phase(start_phase_b),
        .tx_busy(tx_busy_b), .tx_done(tx_done_b)
    );

    always_comb begin
        o_ready[0] = tx_ready_a;      o_ready[1] = tx_ready_b;
        o_li[0]    = line_inactive_a; o_li[1]    = line_inactive_b;
        o_sp[0]    = start_phase_a;   o_sp[1]    = start_phase_b;
        o_busy[0]  = tx_busy_a;       o_busy[1]  = tx_busy_b;
        o_done[0]  = tx_done_a;       o_done[1]  = tx_done_b;
        o_data[0]  = bit_data_a;      o_data[1]  = bit_data_b;
        o_sel[0]   = bit_sel_a;       o_sel[1]   = bit_sel_b;
    end

    function automatic int frame_len(input int i);
        return (i == 0) ? 10 * C : 11 * C;
    endfunction

    function automatic logic line_of(input int i);
        if (o_li[i]) return 1'b1;
        if (o_sp[i]) return 1'b0;
        return o_data[i][o_sel[i]];
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s observed %0h expected %0h at %0t", tag, observed, expected, $time);
        end
    endtask

    // Model tracks only the position k within the frame; everything else follows from k.
    task automatic model_step(input int i, input logic rst);
        if (!rst) begin
            m_active[i] = 1'b0;
            m_k[i]      = 0;
            m_byte[i]   = 8'h00;
        end else if (m_active[i]) begin
            m_k[i]++;
            if (m_k[i] == frame_len(i)) begin
                m_active[i] = 1'b0;
                m_frames[i]++;
            end
        end else if (tx_valid[i]) begin
            m_active[i]     = 1'b1;
            m_k[i]          = 0;
            m_byte[i]       = tx_byte[i];
            m_prev_start[i] = m_last_start[i];
            m_last_start[i] = $time;
            m_starts[i]++;
        end
    endtask

    always @(posedge clk or negedge rst_n0) model_step(0, rst_n0);
    always @(posedge clk or negedge rst_n1) model_step(1, rst_n1);

    always @(negedge clk) begin
        int k;
        logic e_line, e_li, e_sp, e_busy, e_done;
        logic [2:0] e_sel;
        for (int i = 0; i < 2; i++) begin
            if (o_done[i]) dut_done[i]++;
            k = m_k[i];
            if (m_active[i]) begin
                e_busy = 1'b1;
                e_done = (k == frame_len(i) - 1);
                e_sp   = (k < C);
                e_li   = (k >= 9 * C);
                if (k < C) begin
                    e_sel = 3'd0; e_line = 1'b0;
                end else if (k < 9 * C) begin
                    e_sel = 3'((k - C) / C); e_line = m_byte[i][(k - C) / C];
                end else begin
                    e_sel = 3'd7; e_line = 1'b1;
                end
            end else begin
                e_busy = 1'b0; e_done = 1'b0; e_sp = 1'b0; e_li = 1'b1;
                e_sel = 3'd0; e_line = 1'b1;
            end
            checkOutput($sformatf("line%0d", i), 32'(line_of(i)), 32'(e_line));
            checkOutput($sformatf("inactive%0d", i), 32'(o_li[i]), 32'(e_li));
            checkOutput($sformatf("start%0d", i), 32'(o_sp[i]), 32'(e_sp));
            checkOutput($sformatf("sel%0d", i), 32'(o_sel[i]), 32'(e_sel));
            checkOutput($sformatf("busy%0d", i), 32'(o_busy[i]), 32'(e_busy));
            checkOutput($sformatf("ready%0d", i), 32'(o_ready[i]), 32'(!e_busy));
            checkOutput($sformatf("done%0d", i), 32'(o_done[i]), 32'(e_done));
            checkOutput($sformatf("data%0d", i), 32'(o_data[i]), 32'(m_byte[i]));
        end
    end

    task automatic applyStimulus(input int i, input logic [7:0] b, input logic v);
        @(negedge clk);
        tx_byte[i]  = b;
        tx_valid[i] = v;
    endtask

    task automatic send_byte(input int i, input logic [7:0] b);
        applyStimulus(i, b, 1'b1);
        applyStimulus(i, b, 1'b0);
    endtask

    task automatic wait_done(input int i, input int limit);
        int n = 0;
        while (!o_done[i] && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (!o_done[i]) checkOutput($sformatf("timeout_done%0d", i), 32'd0, 32'd1);
    endtask

    task automatic wait_starts(input int i, input int target, input int limit);
        int n = 0;
        while (m_starts[i] < target && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (m_starts[i] < target) checkOutput($sformatf("timeout_start%0d", i), 32'd0, 32'd1);
    endtask

    initial begin
        int done_before;
        int n;
        time t0;

        // Reset state
        repeat (3) @(negedge clk);
        checkOutput("rst_ready", 32'(tx_ready_a), 32'd1);
        checkOutput("rst_line", 32'(line_of(0)), 32'd1);
        checkOutput("rst_data", 32'(bit_data_a), 32'h00);
        #2 rst_n0 = 1'b1; rst_n1 = 1'b1;

        // Single frame 8'hA5 with tx_ready returning the cycle after tx_done
        send_byte(0, 8'hA5);
        t0 = m_last_start[0];
        wait_done(0, 60);
        checkOutput("a5_done_pos", 32'(($time - t0 - 5) / 10), 32'(10 * C - 1));
        @(negedge clk);
        checkOutput("a5_ready_after", 32'(tx_ready_a), 32'd1);

        // Back-to-back 8'h00 then 8'hFF with tx_valid held
        n = m_starts[0];
        applyStimulus(0, 8'h00, 1'b1);
        wait_starts(0, n + 1, 10);
        applyStimulus(0, 8'hFF, 1'b1);
        wait_starts(0, n + 2, 60);
        applyStimulus(0, 8'hFF, 1'b0);
        checkOutput("b2b_gap", 32'((m_last_start[0] - m_prev_start[0]) / 10), 32'(10 * C + 1));
        wait_done(0, 60);
        @(negedge clk);

        // Busy rejection: 8'h3C offered during DATA of an 8'h81 frame
        #1 done_before = dut_done[0];
        send_byte(0, 8'h81);
        repeat (3 * C) @(negedge clk);
        send_byte(0, 8'h3C);
        wait_done(0, 60);
        repeat (5) @(negedge clk);
        #1;
        checkOutput("busy_data", 32'(bit_data_a), 32'h81);
        checkOutput("busy_one_done", 32'(dut_done[0] - done_before), 32'd1);

        // Two stop bits, byte 8'h01
        send_byte(1, 8'h01);
        t0 = m_last_start[1];
        wait_done(1, 80);
        checkOutput("stop2_len", 32'(($time - t0 - 5) / 10 + 1), 32'(11 * C));
        @(negedge clk);

        // Reset during data bit 3
        #1 done_before = dut_done[0];
        send_byte(0, 8'hC3);
        n = 0;
        while (m_k[0] != 4 * C + 1 && n < 60) begin
            @(negedge clk);
            n++;
        end
        if (m_k[0] != 4 * C + 1) checkOutput("timeout_bit3", 32'd0, 32'd1);
        #2 rst_n0 = 1'b0;
        #1;
        checkOutput("midrst_inactive", 32'(line_inactive_a), 32'd1);
        checkOutput("midrst_start", 32'(start_phase_a), 32'd0);
        checkOutput("midrst_busy", 32'(tx_busy_a), 32'd0);
        checkOutput("midrst_ready", 32'(tx_ready_a), 32'd1);
        @(negedge clk);
        #2 rst_n0 = 1'b1;
        repeat (12 * C) @(negedge clk);
        #1;
        checkOutput("midrst_no_done", 32'(dut_done[0] - done_before), 32'd0);
        send_byte(0, 8'h5A);
        wait_done(0, 60);
        repeat (3) @(negedge clk);
        #1;
        checkOutput("midrst_next_done", 32'(dut_done[0] - done_before), 32'd1);

        // Randomized traffic on both instances
        for (int cyc = 0; cyc < 1500; cyc++) begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                tx_byte[i]  = 8'($urandom);
                tx_valid[i] = ($urandom_range(0, 3) == 0);
            end
        end
        @(negedge clk);
        tx_valid[0] = 1'b0;
        tx_valid[1] = 1'b0;
        repeat (15 * C) @(negedge clk);
        #1;
        checkOutput("rand_frames0", 32'(dut_done[0]), 32'(m_frames[0]));
        checkOutput("rand_frames1", 32'(dut_done[1]), 32'(m_frames[1]));

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
